// File: rtl/pad_drive_sequencer.sv
// Staged pad drive-enable sequencer: enables pads group by group, holds, then releases in reverse order.
// Optional feature macro PAD_SEQ_ABORT_EN: stop during ramp-up turns straight into ramp-down.
module pad_drive_sequencer #(
    parameter int unsigned NUM_PADS   = 11,
    parameter int unsigned GROUP_SIZE = 4,
    parameter int unsigned GAP_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tie_level,
    input  logic                start,
    input  logic                stop,
    output logic [NUM_PADS-1:0] pad_oe,
    output logic                pad_val,
    output logic                busy,
    output logic                done
);

    localparam int unsigned NGROUPS = (NUM_PADS + GROUP_SIZE - 1) / GROUP_SIZE;
    localparam int unsigned GW      = $clog2(NGROUPS + 1);
    localparam logic [7:0]    GAP_RELOAD = 8'(GAP_CYCLES - 1);
    localparam logic [GW-1:0] LAST_CNT   = GW'(NGROUPS);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        HOLD      = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    state_t        state;
    logic [7:0]    gap_cnt;
    logic [GW-1:0] grp_cnt;  // number of groups currently enabled
    logic [GW-1:0] grp_inc;
    logic [GW-1:0] grp_dec;

    assign grp_inc = grp_cnt + GW'(1);
    assign grp_dec = grp_cnt - GW'(1);

    // Mask with the lowest n groups enabled; the last group may be partial.
    function automatic logic [NUM_PADS-1:0] group_mask(input logic [GW-1:0] n);
        logic [NUM_PADS-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < NUM_PADS; i++) begin
            m[i] = (i < 32'(n) * GROUP_SIZE);
        end
        return m;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gap_cnt <= '0;
            grp_cnt <= '0;
            pad_oe  <= '0;
            pad_val <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pad_val <= tie_level;
                        grp_cnt <= GW'(1);
                        pad_oe  <= group_mask(GW'(1));
                        gap_cnt <= GAP_RELOAD;
                        if (NGROUPS == 1) begin
                            state <= HOLD;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= RAMP_UP;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                end

                RAMP_UP: begin
`ifdef PAD_SEQ_ABORT_EN
                    if (stop) begin
                        // Abort wins over a coincident step: release the highest group already on.
                        grp_cnt <= grp_dec;
                        pad_oe  <= group_mask(grp_dec);
                        gap_cnt <= GAP_RELOAD;
                        if (grp_cnt == GW'(1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= RAMP_DOWN;
                            busy  <= 1'b1;
                        end
                        done <= 1'b0;
                    end else
`endif
                    if (gap_cnt == 8'd0) begin
                        grp_cnt <= grp_inc;
                        pad_oe  <= group_mask(grp_inc);
                        gap_cnt <= GAP_RELOAD;
                        if (grp_inc == LAST_CNT) begin
                            state <= HOLD;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end

                HOLD: begin
                    if (stop) begin
                        grp_cnt <= grp_dec;
                        pad_oe  <= group_mask(grp_dec);
                        gap_cnt <= GAP_RELOAD;
                        done    <= 1'b0;
                        if (grp_cnt == GW'(1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= RAMP_DOWN;
                            busy  <= 1'b1;
                        end
                    end
                end

                RAMP_DOWN: begin
                    if (gap_cnt == 8'd0) begin
                        grp_cnt <= grp_dec;
                        pad_oe  <= group_mask(grp_dec);
                        gap_cnt <= GAP_RELOAD;
                        if (grp_cnt == GW'(1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pad_drive_sequencer.sv
// Bench for pad_drive_sequencer: directed vectors, async-reset and single-group corner cases, random run vs. a timing model.
module tb_pad_drive_sequencer;

    localparam int NP  = 11;
    localparam int GS  = 4;
    localparam int GAP = 8;
    localparam int NG  = (NP + GS - 1) / GS;
`ifdef PAD_SEQ_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          tie_level, start, stop;
    logic [NP-1:0] pad_oe;
    logic          pad_val, busy, done;

    logic          tie1, start1, stop1;
    logic [NP-1:0] pad_oe1;
    logic          pad_val1, busy1, done1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pad_drive_sequencer #(.NUM_PADS(NP), .GROUP_SIZE(GS), .GAP_CYCLES(GAP)) u_dut (
        .clk(clk), .rst(rst), .tie_level(tie_level), .start(start), .stop(stop),
        .pad_oe(pad_oe), .pad_val(pad_val), .busy(busy), .done(done)
    );

    pad_drive_sequencer #(.NUM_PADS(NP), .GROUP_SIZE(NP), .GAP_CYCLES(GAP)) u_dut1 (
        .clk(clk), .rst(rst), .tie_level(tie1), .start(start1), .stop(stop1),
        .pad_oe(pad_oe1), .pad_val(pad_val1), .busy(busy1), .done(done1)
    );

    // Reference model: enabled-group count from elapsed time since the start/stop edge.
    typedef enum int {M_IDLE, M_UP, M_HOLD, M_DOWN} mphase_t;
    mphase_t m_ph;
    int      m_t, m_k, m_m, m_n0, m_n;
    logic    m_val;

    task automatic model_reset();
        m_ph = M_IDLE; m_t = 0; m_k = 0; m_m = 0; m_n0 = 0; m_n = 0; m_val = 1'b0;
    endtask

    task automatic model_edge(input logic st, input logic sp, input logic tie);
        m_t++;
        case (m_ph)
            M_IDLE: if (st) begin m_k = m_t; m_val = tie; m_ph = M_UP; end
            M_UP:   if (ABORT && sp) begin m_m = m_t; m_n0 = m_n; m_ph = M_DOWN; end
            M_HOLD: if (sp) begin m_m = m_t; m_n0 = NG; m_ph = M_DOWN; end
            default: ;
        endcase
        if (m_ph == M_UP) begin
            m_n = 1 + (m_t - m_k) / GAP;
            if (m_n >= NG) begin m_n = NG; m_ph = M_HOLD; end
        end else if (m_ph == M_DOWN) begin
            m_n = m_n0 - 1 - (m_t - m_m) / GAP;
            if (m_n <= 0) begin m_n = 0; m_ph = M_IDLE; end
        end
    endtask

    function automatic logic [NP-1:0] exp_mask(input int n);
        int   bits;
        logic [63:0] w;
        bits = (n * GS > NP) ? NP : n * GS;
        w = (64'd1 << bits) - 64'd1;
        return NP'(w);
    endfunction

    task automatic cmp(input string nm, input logic [NP+2:0] act, input logic [NP+2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t {oe,val,busy,done} actual=%h expected=%h", nm, $time, act, exp);
        end
    endtask

    task automatic check_model(input string nm);
        cmp(nm, {pad_oe, pad_val, busy, done},
            {exp_mask(m_n), m_val, (m_ph == M_UP || m_ph == M_DOWN), (m_ph == M_HOLD)});
    endtask

    task automatic tick(input logic st, input logic sp, input logic tie, input string nm);
        start = st; stop = sp; tie_level = tie;
        @(posedge clk);
        model_edge(st, sp, tie);
        #1;
        check_model(nm);
        start = 1'b0; stop = 1'b0;
    endtask

    // Asynchronous reset pulse between clock edges, checked before any edge occurs.
    task automatic async_reset(input string nm);
        #2 rst = 1'b1;
        model_reset();
        #1;
        cmp(nm, {pad_oe, pad_val, busy, done}, '0);
        #1 rst = 1'b0;
    endtask

    typedef struct {
        int            pre;
        logic          st, sp, tie;
        logic [NP-1:0] oe;
        logic          bz, dn, pv;
    } vec_t;

    vec_t vecs[11];

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; tie_level = 1'b0;
        tie1 = 1'b0; start1 = 1'b0; stop1 = 1'b0;
        model_reset();
        #12;
        cmp("reset_state", {pad_oe, pad_val, busy, done}, '0);
        cmp("reset_state1", {pad_oe1, pad_val1, busy1, done1}, '0);
        @(negedge clk) rst = 1'b0;
        #1;

        vecs[0]  = '{9,  1'b1, 1'b0, 1'b1, 11'h00F, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{7,  1'b0, 1'b0, 1'b0, 11'h0FF, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{7,  1'b0, 1'b0, 1'b0, 11'h7FF, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{13, 1'b0, 1'b1, 1'b0, 11'h0FF, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{7,  1'b0, 1'b0, 1'b0, 11'h00F, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{7,  1'b0, 1'b0, 1'b0, 11'h000, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{0,  1'b0, 1'b1, 1'b0, 11'h000, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{0,  1'b1, 1'b1, 1'b0, 11'h00F, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{0,  1'b1, 1'b0, 1'b1, 11'h00F, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{6,  1'b0, 1'b0, 1'b1, 11'h0FF, 1'b1, 1'b0, 1'b0};
`ifdef PAD_SEQ_ABORT_EN
        vecs[10] = '{0,  1'b0, 1'b1, 1'b1, 11'h00F, 1'b1, 1'b0, 1'b0};
`else
        vecs[10] = '{0,  1'b0, 1'b1, 1'b1, 11'h0FF, 1'b1, 1'b0, 1'b0};
`endif

        for (int i = 0; i < 11; i++) begin
            repeat (vecs[i].pre) tick(1'b0, 1'b0, ~vecs[i].tie, "vec_gap");
            tick(vecs[i].st, vecs[i].sp, vecs[i].tie, "vec_model");
            cmp($sformatf("vec%0d", i), {pad_oe, pad_val, busy, done},
                {vecs[i].oe, vecs[i].pv, vecs[i].bz, vecs[i].dn});
        end

        // Drain back to IDLE whichever way the abort feature is built.
        repeat (20) tick(1'b0, 1'b0, 1'b1, "drain");
        tick(1'b0, 1'b1, 1'b1, "drain_stop");
        repeat (30) tick(1'b0, 1'b0, 1'b1, "drain");
        cmp("drained_idle", {pad_oe, pad_val, busy, done}, {11'h000, 1'b0, 1'b0, 1'b0});

        // Reset in the middle of a ramp abandons it; a fresh start begins at group 0.
        tick(1'b1, 1'b0, 1'b1, "rst_seq_start");
        repeat (9) tick(1'b0, 1'b0, 1'b0, "rst_seq_ramp");
        cmp("pre_rst_ramp", {pad_oe, pad_val, busy, done}, {11'h0FF, 1'b1, 1'b1, 1'b0});
        async_reset("async_rst");
        repeat (3) tick(1'b0, 1'b0, 1'b1, "post_rst_idle");
        cmp("post_rst_wait", {pad_oe, pad_val, busy, done}, '0);
        tick(1'b1, 1'b0, 1'b1, "restart");
        cmp("restart_grp0", {pad_oe, pad_val, busy, done}, {11'h00F, 1'b1, 1'b1, 1'b0});
        repeat (30) tick(1'b0, 1'b0, 1'b0, "restart_ramp");
        tick(1'b0, 1'b1, 1'b0, "restart_stop");
        repeat (20) tick(1'b0, 1'b0, 1'b0, "restart_down");

        // Single-group build: start goes straight to HOLD, later starts ignored.
        tie1 = 1'b0; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b1; tie1 = 1'b1;
        cmp("one_grp_start", {pad_oe1, pad_val1, busy1, done1}, {11'h7FF, 1'b0, 1'b0, 1'b1});
        repeat (3) @(posedge clk);
        #1;
        cmp("one_grp_start_held", {pad_oe1, pad_val1, busy1, done1}, {11'h7FF, 1'b0, 1'b0, 1'b1});
        start1 = 1'b0; stop1 = 1'b1;
        @(posedge clk); #1;
        stop1 = 1'b0;
        cmp("one_grp_stop", {pad_oe1, pad_val1, busy1, done1}, {11'h000, 1'b0, 1'b0, 1'b0});

        // Random run against the model, with occasional asynchronous resets.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                async_reset("rand_rst");
            end else begin
                tick(($urandom_range(0, 29) == 0), ($urandom_range(0, 19) == 0),
                     1'($urandom_range(0, 1)), "random");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pad_drive_sequencer.md
PAD_DRIVE_SEQUENCER -- requirements
Module: pad_drive_sequencer

Interface
REQ-001 Parameter NUM_PADS, default 11, number of pad inputs driven; legal range 1..64.
REQ-002 Parameter GROUP_SIZE, default 4, pads enabled per step; legal range 1..NUM_PADS.
REQ-003 Parameter GAP_CYCLES, default 8, clock cycles between successive group steps; legal range 1..255.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 tie_level  input  1  constant level (from tie cell) to present on enabled pads.
REQ-007 start  input  1  request ramp-up; sampled only in IDLE.
REQ-008 stop  input  1  request ramp-down; sampled in HOLD, and in RAMP_UP when PAD_SEQ_ABORT_EN is defined.
REQ-009 pad_oe  output  NUM_PADS  per-pad drive-enable mask, registered.
REQ-010 pad_val  output  1  registered copy of tie_level captured at start.
REQ-011 busy  output  1  high in RAMP_UP and RAMP_DOWN.
REQ-012 done  output  1  high in HOLD.

Function
REQ-013 Pads SHALL be grouped by index: group g = bits [g*GROUP_SIZE .. min((g+1)*GROUP_SIZE, NUM_PADS)-1]; NGROUPS = ceil(NUM_PADS/GROUP_SIZE); last group may be partial.
REQ-014 FSM states SHALL be IDLE, RAMP_UP, HOLD, RAMP_DOWN; encoding is implementer's choice.
REQ-015 IDLE, start=1 at edge k: pad_val <= tie_level, group 0 bits of pad_oe set at edge k, state -> RAMP_UP (or HOLD if NGROUPS=1).
REQ-016 RAMP_UP: group g bits SHALL set at edge k+g*GAP_CYCLES; gap counter reloads on every step.
REQ-017 On the edge setting the last group, state -> HOLD; with defaults, groups 0/1/2 set at k, k+8, k+16.
REQ-018 pad_oe bits SHALL only change on group steps; no bit outside the current group changes on a step.
REQ-019 HOLD, stop=1 at edge m: highest set group cleared at edge m, next-lower at m+GAP_CYCLES, ...; state -> IDLE on the edge clearing group 0.
REQ-020 pad_val SHALL hold its captured value until the next accepted start; tie_level changes outside IDLE are ignored.
REQ-021 start outside IDLE and stop in IDLE SHALL be ignored; start and stop both high in IDLE: start accepted, stop ignored.
REQ-022 Gap counter width SHALL be 8 bits; group index width ceil(log2(NGROUPS+1)); no wrap beyond NGROUPS-1.

Reset
REQ-023 rst high SHALL immediately force state IDLE, pad_oe=0, pad_val=0, busy=0, done=0, counters=0, regardless of clock.
REQ-024 rst mid-ramp SHALL abandon the sequence; after release, block waits in IDLE for a fresh start.
REQ-025 First state change after rst deassertion SHALL occur no earlier than the first subsequent rising clk edge.

Configuration
REQ-026 Macro PAD_SEQ_ABORT_EN: when defined, stop=1 in RAMP_UP at edge a SHALL switch to RAMP_DOWN, clearing the highest currently-set group at edge a, then descending per REQ-019.
REQ-027 Without PAD_SEQ_ABORT_EN, stop in RAMP_UP SHALL be ignored (not latched); ramp-up completes to HOLD.

Verification
REQ-028 Defaults, tie_level=1, start pulse at edge 10 -> pad_oe 0x00F @10, 0x0FF @18, 0x7FF @26 with done=1, busy 1 from 10 to 25, pad_val=1.
REQ-029 From HOLD, stop pulse at edge 40 -> pad_oe 0x0FF @40, 0x00F @48, 0x000 @56, state IDLE, busy low after 56.
REQ-030 rst asserted between clock edges at cycle 20 of ramp-up -> pad_oe=0, busy=0 asynchronously; start after release restarts from group 0.
REQ-031 PAD_SEQ_ABORT_EN defined, start at 10, stop at 20 -> pad_oe 0x00F @20, 0x000 @28, IDLE; undefined -> stop ignored, 0x7FF @26.
REQ-032 NUM_PADS=11, GROUP_SIZE=11, tie_level=0 -> pad_oe 0x7FF on start edge, done next state, pad_val=0; start held high in HOLD -> no change.
